// File: rtl/seg7_share_sched.sv
// seg7_share_sched
//   Shares one 8-digit seven-segment display between N_REQ requesters.
//   One requester owns the display at a time. Ownership rotates round-robin
//   once the owner has held it for DWELL cycles and someone else is waiting.
//   With no requests, IDLE_WORD is shown.
//
// Ports
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   req       : level request per requester
//   data_in   : requester i's display word on [32*i +: 32]
//   grant     : one-hot current owner, zero when idle
//   owner     : index of current owner, zero when idle
//   busy      : an owner exists
//   swap      : one-cycle pulse whenever grant changes
//   disp_data : word for the display driver, aligned with grant
module seg7_share_sched #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DWELL     = 50_000_000,
  parameter logic [31:0] IDLE_WORD = 32'h0000_0000,
  localparam int unsigned OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned DW       = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  data_in,
  output logic [N_REQ-1:0]     grant,
  output logic [OW-1:0]        owner,
  output logic                 busy,
  output logic                 swap,
  output logic [31:0]          disp_data
);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t             r_state, w_nxt_state;
  logic [OW-1:0]      r_owner, w_nxt_owner;
  logic [OW-1:0]      r_rr_ptr;
  logic [DW-1:0]      r_dwell, w_nxt_dwell;
  logic [N_REQ-1:0]   r_grant, w_nxt_grant;
  logic               r_busy;
  logic               r_swap;
  logic [31:0]        r_disp, w_nxt_disp;
  logic               w_chg;
  logic               w_own_req;
  logic               w_others;
  logic               w_dwell_done;
  logic [OW:0]        w_pick_rr;
  logic [OW:0]        w_pick_nx;

  // Index after x, wrapping at N_REQ.
  function automatic logic [OW-1:0] f_inc(input logic [OW-1:0] x);
    return (x == OW'(N_REQ - 1)) ? '0 : x + OW'(1);
  endfunction

  // First requester scanning from ptr with wrap; MSB flags that one was found.
  function automatic logic [OW:0] f_pick(input logic [N_REQ-1:0] rq,
                                         input logic [OW-1:0]    ptr);
    logic [OW:0] res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!res[OW] && rq[OW'(idx)]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    w_pick_rr    = f_pick(req, r_rr_ptr);
    // Scanning from owner+1 visits the owner last, so a competitor always wins
    // on rotation and a released owner can never be re-picked.
    w_pick_nx    = f_pick(req, f_inc(r_owner));
    w_own_req    = |(req & r_grant);
    w_others     = |(req & ~r_grant);
    w_dwell_done = (r_dwell == DW'(DWELL - 1));

    w_nxt_state  = r_state;
    w_nxt_owner  = r_owner;
    w_chg        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_chg       = 1'b1;
          w_nxt_state = S_SHOW;
          w_nxt_owner = w_pick_rr[OW-1:0];
        end
      end
      S_SHOW: begin
        if (!w_own_req) begin
          w_chg = 1'b1;
          if (w_pick_nx[OW]) begin
            w_nxt_owner = w_pick_nx[OW-1:0];
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_owner = '0;
          end
        end else if (w_dwell_done && w_others) begin
          w_chg       = 1'b1;
          w_nxt_owner = w_pick_nx[OW-1:0];
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_owner = '0;
      end
    endcase

    // Dwell saturates so a late competitor takes over on its first cycle.
    w_nxt_dwell = r_dwell;
    if (w_chg)
      w_nxt_dwell = '0;
    else if (r_state == S_SHOW && !w_dwell_done)
      w_nxt_dwell = r_dwell + DW'(1);

    // Grant and display word are built from the next owner so both land in
    // the same cycle.
    w_nxt_grant = '0;
    w_nxt_disp  = IDLE_WORD;
    if (w_nxt_state == S_SHOW) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (OW'(i) == w_nxt_owner) begin
          w_nxt_grant[i] = 1'b1;
          w_nxt_disp     = data_in[32*i +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_dwell  <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_swap   <= 1'b0;
      r_disp   <= IDLE_WORD;
    end else begin
      r_state <= w_nxt_state;
      r_owner <= w_nxt_owner;
      r_dwell <= w_nxt_dwell;
      r_grant <= w_nxt_grant;
      r_busy  <= (w_nxt_state == S_SHOW);
      r_swap  <= w_chg;
      r_disp  <= w_nxt_disp;
      if (w_chg && w_nxt_state == S_SHOW)
        r_rr_ptr <= f_inc(w_nxt_owner);
    end
  end

  assign grant     = r_grant;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign swap      = r_swap;
  assign disp_data = r_disp;

endmodule

// File: tb/tb_seg7_share_sched.sv
// tb_seg7_share_sched
//   Directed bench for seg7_share_sched with N_REQ=4, DWELL=8,
//   data_in[i] = 32'hA0A0_0000 + i. Expected values are hand-derived.
module tb_seg7_share_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [32*N-1:0] data_in;
  logic [N-1:0]  grant;
  logic [1:0]    owner;
  logic          busy;
  logic          swap;
  logic [31:0]   disp_data;

  int unsigned n_checks;
  int unsigned n_fail;

  seg7_share_sched #(
    .N_REQ     (N),
    .DWELL     (DW),
    .IDLE_WORD (32'h0000_0000)
  ) u_dut (
    .clk       (clk),
    .reset     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy),
    .swap      (swap),
    .disp_data (disp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    rst_n = 1'b0;
    req   = '0;
    #3;
    @(posedge clk);
    #1;
    req   = r;
    rst_n = 1'b1;
  endtask

  task automatic check_owner(input string tag, input int unsigned o, input logic exp_swap);
    check({tag, "_grant"}, 32'(grant), 32'(1) << o);
    check({tag, "_owner"}, 32'(owner), o);
    check({tag, "_busy"},  32'(busy),  32'd1);
    check({tag, "_swap"},  32'(swap),  32'(exp_swap));
    check({tag, "_disp"},  disp_data,  32'hA0A0_0000 + o);
  endtask

  task automatic check_idle(input string tag, input logic exp_swap);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_swap"},  32'(swap),  32'(exp_swap));
    check({tag, "_disp"},  disp_data,  32'd0);
  endtask

  int unsigned rot_seq [5] = '{0, 1, 3, 0, 1};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = '0;
    for (int i = 0; i < N; i++) data_in[32*i +: 32] = 32'hA0A0_0000 + 32'(i);

    // Reset values and quiet idle.
    #3;
    check_idle("reset", 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("idle20", 1'b0);
    end

    // Single requester from idle, then data tracking.
    req = 4'b0100;
    tick();
    check_owner("grant2", 2, 1'b1);
    data_in[64 +: 32] = 32'h1234_5678;
    tick();
    check("track_disp", disp_data, 32'h1234_5678);
    check("track_swap", 32'(swap), 32'd0);
    data_in[64 +: 32] = 32'hA0A0_0002;
    req = 4'b0000;
    tick();
    check_idle("rel2_idle", 1'b1);
    tick();
    check("rel2_swap_off", 32'(swap), 32'd0);

    // rr_ptr survives idle: it is 3 after owner 2, so 3 beats 0.
    req = 4'b1001;
    tick();
    check_owner("rrptr3", 3, 1'b1);
    req = 4'b0000;
    tick();
    check_idle("rrptr3_rel", 1'b1);
    tick();

    // One-cycle request pulse: granted once, then released (two swaps).
    req = 4'b0001;
    tick();
    check_owner("pulse_grant", 0, 1'b1);
    req = 4'b0000;
    tick();
    check_idle("pulse_rel", 1'b1);
    tick();
    check("pulse_swap_off", 32'(swap), 32'd0);

    // Round-robin rotation with dwell of 8 cycles.
    do_reset(4'b1011);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_owner($sformatf("rot%0d", k), rot_seq[k], 1'b1);
      for (int c = 1; c < DW; c++) begin
        tick();
        check($sformatf("rot%0d_hold%0d", k, c), 32'(grant), 32'(1) << rot_seq[k]);
        check($sformatf("rot%0d_swap%0d", k, c), 32'(swap), 32'd0);
      end
    end

    // Long solo hold, then a late competitor takes over after one cycle.
    do_reset(4'b0001);
    tick();
    check_owner("solo0", 0, 1'b1);
    for (int c = 0; c < 30; c++) begin
      tick();
      check($sformatf("solo_hold%0d", c), 32'(grant), 32'd1);
      check($sformatf("solo_swap%0d", c), 32'(swap), 32'd0);
    end
    req = 4'b1001;
    tick();
    check_owner("late3", 3, 1'b1);

    // Early release hands over regardless of dwell; then release to idle.
    do_reset(4'b0010);
    tick();
    check_owner("early1", 1, 1'b1);
    req = 4'b0110;
    tick();
    tick();
    check("early1_kept", 32'(grant), 32'd2);
    req = 4'b0100;
    tick();
    check_owner("early_to2", 2, 1'b1);
    tick();
    check("early2_swap_off", 32'(swap), 32'd0);
    req = 4'b0000;
    tick();
    check_idle("early2_idle", 1'b1);

    // Asynchronous reset in the middle of SHOW.
    do_reset(4'b1000);
    tick();
    check_owner("mid3", 3, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check_idle("async_rst", 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_owner("post_rst3", 3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
